// File: rtl/inst_prefetch_pkg.sv
// Shared constants and the queued fetch-entry layout for the instruction prefetch unit.
package inst_prefetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TERMINATOR_WORD  = 32'h0000_0000;
   localparam logic [31:0] INST_STEP        = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Parameterised synchronous FIFO; clear has priority over push and pop.
module inst_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       clrn,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign data  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & !empty;
      do_push  = push & (!full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; contents are only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch: addresses the combinational ROM, queues {pc, inst} for decode,
// restarts on redirect and idles after fetching the all-zero terminator word.
module inst_prefetch
   import inst_prefetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        clrn,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_inst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        stopped
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic         stopped_q, stopped_d;
   logic         pop, push, can_push;
   logic         fifo_full, fifo_empty;
   logic [AW:0]  fifo_count;
   fetch_entry_t wr_entry, head_entry;

   assign imem_a    = fetch_pc_q;
   assign stopped   = stopped_q;
   assign out_valid = (fifo_count != '0);
   assign out_inst  = head_entry.inst;
   assign out_pc    = head_entry.pc;

   assign pop      = out_valid & out_ready;
   assign can_push = !stopped_q & (!fifo_full | pop);
   assign wr_entry = '{pc: fetch_pc_q, inst: imem_inst};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      stopped_d  = stopped_q;
      push       = 1'b0;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         stopped_d  = 1'b0;
      end else if (can_push) begin
         if (imem_inst == TERMINATOR_WORD) begin
            stopped_d = 1'b1;
         end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + INST_STEP;
         end
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         fetch_pc_q <= RESET_PC;
         stopped_q  <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         stopped_q  <= stopped_d;
      end
   end

   // A head handshake during a redirect is still consumed by decode; clear wins inside the FIFO.
   inst_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .clrn  (clrn),
      .push  (push),
      .pop   (pop),
      .clear (redirect),
      .wdata (wr_entry),
      .data  (head_entry),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      assert (fifo_empty == (fifo_count == '0));
   end

endmodule

// File: tb/tb_inst_prefetch.sv
// Scoreboard bench for inst_prefetch: a queue-level fetch model predicts every delivered
// {pc, inst}; a negedge monitor pops and compares on each decode handshake.
module tb_inst_prefetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        clrn = 1'b1;
   logic [31:0] imem_a;
   logic [31:0] imem_inst;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        stopped;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] m_pc = 32'h0;
   int          m_count = 0;
   bit          m_stop = 1'b0;
   logic [31:0] last_pc = 32'hFFFF_FFFF;
   bit          seen_term = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   // Test program: known words at 0x0, 0x4, 0x28; terminator at 0xB4; everything else non-zero.
   function automatic logic [31:0] rom_word(input logic [6:0] idx);
      case (idx)
         7'd0:    return 32'hFFC1_0113;
         7'd1:    return 32'h0011_2223;
         7'd10:   return 32'h46A6_C957;
         7'd45:   return 32'h0000_0000;
         default: return 32'h5A00_0013 | (32'(idx) << 7);
      endcase
   endfunction

   assign imem_inst = rom_word(imem_a[8:2]);

   inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .clrn        (clrn),
      .imem_a      (imem_a),
      .imem_inst   (imem_inst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_pc      (out_pc),
      .stopped     (stopped)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = 32'h0;
      m_count = 0;
      m_stop  = 1'b0;
      exp_q.delete();
   endtask

   // One clock edge of the fetch rules, applied to the inputs held during the cycle.
   task automatic model_step();
      bit          pop;
      bit          room;
      logic [31:0] w;
      pop  = (m_count > 0) && out_ready;
      room = (m_count < DEPTH);
      if (redirect) begin
         exp_q.delete();
         m_count = 0;
         m_pc    = {redirect_pc[31:2], 2'b00};
         m_stop  = 1'b0;
      end else begin
         if (pop) m_count--;
         if (!m_stop && (room || pop)) begin
            w = rom_word(m_pc[8:2]);
            if (w != 32'h0) begin
               exp_q.push_back('{pc: m_pc, inst: w});
               m_count++;
               m_pc = m_pc + 32'd4;
            end else begin
               m_stop = 1'b1;
            end
         end
      end
   endtask

   task automatic drive(input bit rdy, input bit rd, input logic [31:0] rpc);
      out_ready   = rdy;
      redirect    = rd;
      redirect_pc = rpc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_step();
   endtask

   // Asserts reset between edges, checks the asynchronous effect, releases after one edge.
   task automatic do_reset();
      #2;
      clrn = 1'b0;
      model_reset();
      #1;
      check1("rst_out_valid", out_valid, 1'b0);
      check32("rst_imem_a", imem_a, 32'h0);
      @(posedge clk);
      #2;
      clrn = 1'b1;
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         check1("out_valid", out_valid, exp_q.size() != 0);
         check32("imem_a", imem_a, m_pc);
         check1("stopped", stopped, m_stop);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_pop at %0t: got pc %h expected no entry", $time, out_pc);
            end else begin
               e = exp_q.pop_front();
               check32("out_pc", out_pc, e.pc);
               check32("out_inst", out_inst, e.inst);
               last_pc = out_pc;
               if (out_pc[8:2] == 7'd45) seen_term = 1'b1;
            end
         end
      end
   end

   initial begin : stimulus
      bit done;

      // Reset release with decode ready.
      drive(1'b1, 1'b0, 32'h0);
      do_reset();
      step(); #1;
      check1("first_valid", out_valid, 1'b1);
      check32("first_pc", out_pc, 32'h0);
      check32("first_inst", out_inst, 32'hFFC1_0113);
      step(); #1;
      check32("second_pc", out_pc, 32'h4);
      check32("second_inst", out_inst, 32'h0011_2223);

      // Backpressure, then push and pop at full.
      drive(1'b0, 1'b0, 32'h0);
      do_reset();
      repeat (10) step();
      #1;
      check32("bp_imem_a", imem_a, 32'h10);
      check32("bp_head_pc", out_pc, 32'h0);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 1'b0, 32'h0);
         #1;
         check32("release_pc", out_pc, 32'(4 * k));
         check32("full_flow_imem_a", imem_a, 32'h10 + 32'(4 * k));
         step();
      end

      // Redirect with a full FIFO.
      drive(1'b0, 1'b0, 32'h0);
      repeat (2) step();
      drive(1'b0, 1'b1, 32'h0000_002B);
      step();
      drive(1'b1, 1'b0, 32'h0);
      #1;
      check1("redir_valid_low", out_valid, 1'b0);
      check32("redir_imem_a", imem_a, 32'h28);
      step(); #1;
      check1("redir_valid", out_valid, 1'b1);
      check32("redir_pc", out_pc, 32'h28);
      check32("redir_inst", out_inst, 32'h46A6_C957);

      // Free-run to the terminator.
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (stopped && !out_valid) begin
            done = 1'b1;
            break;
         end
         step(); #1;
      end
      check1("term_reached", done, 1'b1);
      check32("term_last_pc", last_pc, 32'hB0);
      check1("term_stopped", stopped, 1'b1);
      check32("term_imem_a", imem_a, 32'hB4);
      repeat (3) step();
      #1;
      check32("term_imem_a_held", imem_a, 32'hB4);
      drive(1'b1, 1'b1, 32'h0);
      step();
      drive(1'b1, 1'b0, 32'h0);
      #1;
      check1("restart_stopped", stopped, 1'b0);
      check32("restart_imem_a", imem_a, 32'h0);
      step(); #1;
      check32("restart_pc", out_pc, 32'h0);

      // Reset mid-stream with three entries queued.
      drive(1'b0, 1'b0, 32'h0);
      do_reset();
      repeat (3) step();
      check1("pre_rst_valid", out_valid, 1'b1);
      do_reset();
      drive(1'b1, 1'b0, 32'h0);
      step(); #1;
      check32("post_rst_pc", out_pc, 32'h0);
      check32("post_rst_inst", out_inst, 32'hFFC1_0113);

      // Randomised traffic, redirects (including near the top of the address space) and resets.
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] rpc;
         bit          rd;
         rd  = ($urandom_range(0, 24) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 511));
         if (i == 700) begin
            rd  = 1'b1;
            rpc = 32'hFFFF_FFF6;
         end
         drive($urandom_range(0, 9) < 7, rd, rpc);
         if (i % 400 == 399) do_reset();
         step();
      end
      drive(1'b1, 1'b0, 32'h0);
      repeat (3) step();
      #1;

      check1("term_never_delivered", seen_term, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
